// File: rtl/da_pkg.sv
// rtl/da_pkg.sv - shared defaults and return-info type for the reply tag arbiter
package da_pkg;
  localparam int DEF_NUM_REQ          = 4;
  localparam int DEF_ADDRESS_WIDTH    = 4;
  localparam int DEF_VC_ADDRESS_WIDTH = 1;
  localparam int DEF_WIDTH_TAG        = 8;
  localparam int DEF_WIDTH_DATA       = 32;
  localparam int DEF_MAX_OUTSTANDING  = 12;

  // Return routing carried alongside each request until its reply comes back.
  typedef struct packed {
    logic [DEF_WIDTH_TAG-1:0]        tag;
    logic [DEF_ADDRESS_WIDTH-1:0]    dst;
    logic [DEF_VC_ADDRESS_WIDTH-1:0] vc;
  } rtn_info_t;
endpackage

// File: rtl/tag_queue_da.sv
// rtl/tag_queue_da.sv - show-ahead in-order FIFO of return info, any depth >= 2
module tag_queue_da
  import da_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH_TAG + DEF_ADDRESS_WIDTH + DEF_VC_ADDRESS_WIDTH,
  parameter int DEPTH = DEF_MAX_OUTSTANDING
) (
  input  logic                       clk,
  input  logic                       clr,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           head,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty   = (count == '0);
  assign do_push = push && (count != CW'(DEPTH));
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= next_ptr(wr_ptr);
      if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end
endmodule

// File: rtl/reply_tag_arbiter.sv
// rtl/reply_tag_arbiter.sv - round-robin request arbiter with credit-limited in-order reply tagging
module reply_tag_arbiter
  import da_pkg::*;
#(
  parameter int NUM_REQ          = DEF_NUM_REQ,
  parameter int ADDRESS_WIDTH    = DEF_ADDRESS_WIDTH,
  parameter int VC_ADDRESS_WIDTH = DEF_VC_ADDRESS_WIDTH,
  parameter int WIDTH_TAG        = DEF_WIDTH_TAG,
  parameter int WIDTH_DATA       = DEF_WIDTH_DATA,
  parameter int MAX_OUTSTANDING  = DEF_MAX_OUTSTANDING
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [NUM_REQ-1:0]                    i_req_valid,
  input  logic [NUM_REQ*ADDRESS_WIDTH-1:0]      i_req_dst,
  input  logic [NUM_REQ*VC_ADDRESS_WIDTH-1:0]   i_req_vc,
  input  logic [NUM_REQ*WIDTH_TAG-1:0]          i_req_tag,
  input  logic [NUM_REQ*WIDTH_DATA-1:0]         i_req_data,
  output logic [NUM_REQ-1:0]                    o_req_ready,
  output logic                                  o_slv_valid,
  output logic [WIDTH_DATA-1:0]                 o_slv_data,
  input  logic                                  i_slv_ready,
  input  logic                                  i_rsp_valid,
  input  logic [WIDTH_DATA-1:0]                 i_rsp_data,
  output logic                                  o_rsp_ready,
  output logic                                  o_out_valid,
  output logic [WIDTH_DATA-1:0]                 o_out_data,
  output logic [ADDRESS_WIDTH-1:0]              o_out_dst,
  output logic [VC_ADDRESS_WIDTH-1:0]           o_out_vc,
  output logic [WIDTH_TAG-1:0]                  o_out_tag,
  input  logic                                  i_out_ready,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0]  o_outstanding,
  output logic                                  o_err
);
  localparam int RW = $clog2(NUM_REQ);
  localparam int CW = $clog2(MAX_OUTSTANDING + 1);
  localparam int QW = WIDTH_TAG + ADDRESS_WIDTH + VC_ADDRESS_WIDTH;

  logic                        stg_valid;
  logic [WIDTH_DATA-1:0]       stg_data;
  logic [ADDRESS_WIDTH-1:0]    stg_dst;
  logic [VC_ADDRESS_WIDTH-1:0] stg_vc;
  logic [WIDTH_TAG-1:0]        stg_tag;
  logic [RW-1:0]               rr;
  logic [RW-1:0]               grant_idx;
  logic                        grant_found;
  logic                        stage_free;
  logic                        slv_fire;
  logic                        credit_ok;
  logic                        accept;
  logic [QW-1:0]               q_head;
  logic                        q_empty;
  logic [CW-1:0]               q_count;

  assign slv_fire   = stg_valid && i_slv_ready;
  assign stage_free = !stg_valid || i_slv_ready;
  assign credit_ok  = (o_outstanding < CW'(MAX_OUTSTANDING));

  // First valid requester at or after rr, wrapping around.
  always_comb begin
    int idx;
    idx         = 0;
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(rr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!grant_found && i_req_valid[idx]) begin
        grant_found = 1'b1;
        grant_idx   = RW'(idx);
      end
    end
  end

  always_comb begin
    o_req_ready = '0;
    if (grant_found && stage_free && credit_ok && !rst) o_req_ready[grant_idx] = 1'b1;
  end

  assign accept = |(i_req_valid & o_req_ready);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stg_valid <= 1'b0;
      stg_data  <= '0;
      stg_dst   <= '0;
      stg_vc    <= '0;
      stg_tag   <= '0;
    end else if (accept) begin
      stg_valid <= 1'b1;
      stg_data  <= i_req_data[int'(grant_idx)*WIDTH_DATA +: WIDTH_DATA];
      stg_dst   <= i_req_dst[int'(grant_idx)*ADDRESS_WIDTH +: ADDRESS_WIDTH];
      stg_vc    <= i_req_vc[int'(grant_idx)*VC_ADDRESS_WIDTH +: VC_ADDRESS_WIDTH];
      stg_tag   <= i_req_tag[int'(grant_idx)*WIDTH_TAG +: WIDTH_TAG];
    end else if (slv_fire) begin
      stg_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr <= '0;
    end else if (accept) begin
      rr <= (grant_idx == RW'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_err <= 1'b0;
    end else if (i_rsp_valid && q_empty) begin
      o_err <= 1'b1;
    end
  end

  tag_queue_da #(
    .WIDTH (QW),
    .DEPTH (MAX_OUTSTANDING)
  ) u_tag_queue (
    .clk       (clk),
    .clr       (rst),
    .push      (slv_fire),
    .push_data ({stg_tag, stg_dst, stg_vc}),
    .pop       (i_rsp_valid && i_out_ready),
    .head      (q_head),
    .empty     (q_empty),
    .count     (q_count)
  );

  assign o_slv_valid                       = stg_valid;
  assign o_slv_data                        = stg_data;
  assign {o_out_tag, o_out_dst, o_out_vc}  = q_head;
  assign o_out_valid                       = i_rsp_valid && !q_empty;
  assign o_out_data                        = i_rsp_data;
  assign o_rsp_ready                       = i_out_ready;
  assign o_outstanding                     = CW'(stg_valid) + q_count;
endmodule
